// File: rtl/vga_pkg.sv
// Shared 640x480@60 raster constants and display-path types.
// Used by the timing generator and the background/sprite/mixer layers.
package vga_pkg;

  localparam int CNT_W = 12;

  localparam int H_SYNC_PULSE   = 96;
  localparam int H_BACK_PORCH   = 48;
  localparam int H_ACTIVE_TIME  = 640;
  localparam int H_FRONT_PORCH  = 16;
  localparam int H_LINE_PERIOD  = 800;

  localparam int V_SYNC_PULSE   = 2;
  localparam int V_BACK_PORCH   = 33;
  localparam int V_ACTIVE_TIME  = 480;
  localparam int V_FRONT_PORCH  = 10;
  localparam int V_FRAME_PERIOD = 525;

  localparam int SYNC_DELAY = 2;

  localparam int H_ACT_START = H_SYNC_PULSE + H_BACK_PORCH;
  localparam int H_ACT_END   = H_ACT_START + H_ACTIVE_TIME - 1;
  localparam int V_ACT_START = V_SYNC_PULSE + V_BACK_PORCH;
  localparam int V_ACT_END   = V_ACT_START + V_ACTIVE_TIME - 1;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic active;
  } sync_bus_t;

  localparam sync_bus_t SYNC_IDLE = '{
    hsync:  1'b1,
    vsync:  1'b1,
    active: 1'b0
  };

  function automatic logic in_span(
    input cnt_t c,
    input cnt_t lo,
    input cnt_t hi
  );
    return (c >= lo) && (c <= hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen_sync_delay_line.sv
// Fixed-depth shift register with a per-bit reset value.
// Depth 0 degenerates to a plain wire.
module sync_delay_line #(
  parameter int           W       = 3,
  parameter int           DEPTH   = 2,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_thru
      assign q = d;
    end else begin : g_pipe
      logic [W-1:0] stg_q [DEPTH];
      logic [W-1:0] stg_d [DEPTH];

      always_comb begin
        stg_d[0] = d;
        for (int i = 1; i < DEPTH; i++) begin
          stg_d[i] = stg_q[i-1];
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) begin
            stg_q[i] <= RST_VAL;
          end
        end else begin
          stg_q <= stg_d;
        end
      end

      assign q = stg_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Free-running raster timing generator (640x480@60 by default).
// Optional pix_x/pix_y outputs: define VGA_TIMING_PIXEL_XY_EN.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_SYNC_PULSE   = vga_pkg::H_SYNC_PULSE,
  parameter int H_BACK_PORCH   = vga_pkg::H_BACK_PORCH,
  parameter int H_ACTIVE_TIME  = vga_pkg::H_ACTIVE_TIME,
  parameter int H_FRONT_PORCH  = vga_pkg::H_FRONT_PORCH,
  parameter int H_LINE_PERIOD  = vga_pkg::H_LINE_PERIOD,
  parameter int V_SYNC_PULSE   = vga_pkg::V_SYNC_PULSE,
  parameter int V_BACK_PORCH   = vga_pkg::V_BACK_PORCH,
  parameter int V_ACTIVE_TIME  = vga_pkg::V_ACTIVE_TIME,
  parameter int V_FRONT_PORCH  = vga_pkg::V_FRONT_PORCH,
  parameter int V_FRAME_PERIOD = vga_pkg::V_FRAME_PERIOD,
  parameter int SYNC_DELAY     = vga_pkg::SYNC_DELAY
) (
  input  logic             vga_clk,
  input  logic             rst_n,
  input  logic             ena,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt,
  output logic             active,
  output logic             frame_tick,
  output logic             line_tick,
  output logic             hsync_out,
  output logic             vsync_out,
  output logic             active_out
`ifdef VGA_TIMING_PIXEL_XY_EN
  ,
  output logic [9:0]       pix_x,
  output logic [9:0]       pix_y
`endif
);

  localparam int HA0 = H_SYNC_PULSE + H_BACK_PORCH;
  localparam int VA0 = V_SYNC_PULSE + V_BACK_PORCH;

  localparam cnt_t H_LAST = cnt_t'(H_LINE_PERIOD - 1);
  localparam cnt_t V_LAST = cnt_t'(V_FRAME_PERIOD - 1);
  localparam cnt_t HS_END = cnt_t'(H_SYNC_PULSE);
  localparam cnt_t VS_END = cnt_t'(V_SYNC_PULSE);
  localparam cnt_t HA_LO  = cnt_t'(HA0);
  localparam cnt_t HA_HI  = cnt_t'(HA0 + H_ACTIVE_TIME - 1);
  localparam cnt_t VA_LO  = cnt_t'(VA0);
  localparam cnt_t VA_HI  = cnt_t'(VA0 + V_ACTIVE_TIME - 1);

  cnt_t h_q, h_d;
  cnt_t v_q, v_d;
  logic hs_q, hs_d;
  logic vs_q, vs_d;
  logic act_q, act_d;
  logic lt_q, lt_d;
  logic ft_q, ft_d;
`ifdef VGA_TIMING_PIXEL_XY_EN
  logic [9:0] px_q, px_d;
  logic [9:0] py_q, py_d;
`endif

  // Decode looks at the next counter values so it lands with them.
  always_comb begin
    h_d   = h_q;
    v_d   = v_q;
    hs_d  = hs_q;
    vs_d  = vs_q;
    act_d = act_q;
    lt_d  = 1'b0;
    ft_d  = 1'b0;
`ifdef VGA_TIMING_PIXEL_XY_EN
    px_d  = px_q;
    py_d  = py_q;
`endif
    if (ena) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + cnt_t'(1);
      end else begin
        h_d = h_q + cnt_t'(1);
      end
      hs_d  = (h_d >= HS_END);
      vs_d  = (v_d >= VS_END);
      act_d = in_span(h_d, HA_LO, HA_HI)
            && in_span(v_d, VA_LO, VA_HI);
      lt_d  = (h_d == '0);
      ft_d  = (h_d == '0) && (v_d == '0);
`ifdef VGA_TIMING_PIXEL_XY_EN
      px_d  = act_d ? 10'(h_d - HA_LO) : '0;
      py_d  = act_d ? 10'(v_d - VA_LO) : '0;
`endif
    end
  end

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q   <= '0;
      v_q   <= '0;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      act_q <= 1'b0;
      lt_q  <= 1'b0;
      ft_q  <= 1'b0;
`ifdef VGA_TIMING_PIXEL_XY_EN
      px_q  <= '0;
      py_q  <= '0;
`endif
    end else begin
      h_q   <= h_d;
      v_q   <= v_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      act_q <= act_d;
      lt_q  <= lt_d;
      ft_q  <= ft_d;
`ifdef VGA_TIMING_PIXEL_XY_EN
      px_q  <= px_d;
      py_q  <= py_d;
`endif
    end
  end

  sync_bus_t raw_bus;
  sync_bus_t dly_bus;

  assign raw_bus = '{hsync: hs_q, vsync: vs_q, active: act_q};

  sync_delay_line #(
    .W       ($bits(sync_bus_t)),
    .DEPTH   (SYNC_DELAY),
    .RST_VAL (SYNC_IDLE)
  ) u_dly (
    .clk   (vga_clk),
    .rst_n (rst_n),
    .d     (raw_bus),
    .q     (dly_bus)
  );

  assign h_cnt      = h_q;
  assign v_cnt      = v_q;
  assign active     = act_q;
  assign line_tick  = lt_q;
  assign frame_tick = ft_q;
  assign hsync_out  = dly_bus.hsync;
  assign vsync_out  = dly_bus.vsync;
  assign active_out = dly_bus.active;
`ifdef VGA_TIMING_PIXEL_XY_EN
  assign pix_x      = px_q;
  assign pix_y      = py_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: full-size raster (a) plus a shrunken
// raster (b) so whole frames fit in a short run.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a_n = 1'b0, ena_a = 1'b0;
  logic rst_b_n = 1'b0, ena_b = 1'b0;

  logic [11:0] a_h, a_v, b_h, b_v;
  logic a_act, a_ft, a_lt, a_hs, a_vs, a_ao;
  logic b_act, b_ft, b_lt, b_hs, b_vs, b_ao;
`ifdef VGA_TIMING_PIXEL_XY_EN
  logic [9:0] a_px, a_py, b_px, b_py;
`endif

  vga_timing_gen dut_a (
    .vga_clk    (clk),
    .rst_n      (rst_a_n),
    .ena        (ena_a),
    .h_cnt      (a_h),
    .v_cnt      (a_v),
    .active     (a_act),
    .frame_tick (a_ft),
    .line_tick  (a_lt),
    .hsync_out  (a_hs),
    .vsync_out  (a_vs),
    .active_out (a_ao)
`ifdef VGA_TIMING_PIXEL_XY_EN
    ,
    .pix_x      (a_px),
    .pix_y      (a_py)
`endif
  );

  vga_timing_gen #(
    .H_SYNC_PULSE   (6),
    .H_BACK_PORCH   (4),
    .H_ACTIVE_TIME  (20),
    .H_FRONT_PORCH  (2),
    .H_LINE_PERIOD  (32),
    .V_SYNC_PULSE   (2),
    .V_BACK_PORCH   (3),
    .V_ACTIVE_TIME  (12),
    .V_FRONT_PORCH  (2),
    .V_FRAME_PERIOD (19),
    .SYNC_DELAY     (3)
  ) dut_b (
    .vga_clk    (clk),
    .rst_n      (rst_b_n),
    .ena        (ena_b),
    .h_cnt      (b_h),
    .v_cnt      (b_v),
    .active     (b_act),
    .frame_tick (b_ft),
    .line_tick  (b_lt),
    .hsync_out  (b_hs),
    .vsync_out  (b_vs),
    .active_out (b_ao)
`ifdef VGA_TIMING_PIXEL_XY_EN
    ,
    .pix_x      (b_px),
    .pix_y      (b_py)
`endif
  );

  bit sel_b = 1'b0;
  logic [11:0] o_h, o_v;
  logic o_act, o_ft, o_lt, o_hs, o_vs, o_ao;
  assign o_h   = sel_b ? b_h   : a_h;
  assign o_v   = sel_b ? b_v   : a_v;
  assign o_act = sel_b ? b_act : a_act;
  assign o_ft  = sel_b ? b_ft  : a_ft;
  assign o_lt  = sel_b ? b_lt  : a_lt;
  assign o_hs  = sel_b ? b_hs  : a_hs;
  assign o_vs  = sel_b ? b_vs  : a_vs;
  assign o_ao  = sel_b ? b_ao  : a_ao;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: raster position plus a history of raw sync bits.
  int cf_hp, cf_hs, cf_ha0, cf_ha1, cf_vp, cf_vs, cf_va0, cf_va1, cf_d;
  int mh, mv;
  bit m_hs, m_vs, m_act, m_lt, m_ft;
  bit e_hso, e_vso, e_aso;
  logic [2:0] hist[$];

  task automatic use_cfg(input bit b);
    sel_b = b;
    if (!b) begin
      cf_hp = 800; cf_hs = 96; cf_ha0 = 144; cf_ha1 = 783;
      cf_vp = 525; cf_vs = 2;  cf_va0 = 35;  cf_va1 = 514;
      cf_d  = 2;
    end else begin
      cf_hp = 32; cf_hs = 6; cf_ha0 = 10; cf_ha1 = 29;
      cf_vp = 19; cf_vs = 2; cf_va0 = 5;  cf_va1 = 16;
      cf_d  = 3;
    end
  endtask

  task automatic set_exp();
    {e_hso, e_vso, e_aso} = hist[hist.size() - 1 - cf_d];
  endtask

  task automatic model_reset();
    mh = 0; mv = 0;
    m_hs = 1; m_vs = 1; m_act = 0; m_lt = 0; m_ft = 0;
    hist.delete();
    repeat (cf_d + 1) hist.push_back(3'b110);
    set_exp();
  endtask

  task automatic step(input bit en);
    if (sel_b) ena_b = en;
    else       ena_a = en;
    @(posedge clk);
    if (en) begin
      mh++;
      if (mh == cf_hp) begin
        mh = 0;
        mv++;
        if (mv == cf_vp) mv = 0;
      end
      m_hs  = (mh >= cf_hs);
      m_vs  = (mv >= cf_vs);
      m_act = (mh >= cf_ha0) && (mh <= cf_ha1)
           && (mv >= cf_va0) && (mv <= cf_va1);
      m_lt  = (mh == 0);
      m_ft  = (mh == 0) && (mv == 0);
    end else begin
      m_lt = 0;
      m_ft = 0;
    end
    hist.push_back({m_hs, m_vs, m_act});
    if (hist.size() > 16) void'(hist.pop_front());
    set_exp();
    #1;
  endtask

  task automatic test_reset();
    for (int s = 0; s < 2; s++) begin
      use_cfg(bit'(s));
      if (s == 0) ena_a = 1'b1;
      else        ena_b = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_tests++;
      if ({o_h, o_v} !== 24'd0) begin
        n_fail++;
        $display("FAIL reset_cnt: got h=%0d v=%0d expected 0 0", o_h, o_v);
      end
      n_tests++;
      if ({o_act, o_lt, o_ft} !== 3'b000) begin
        n_fail++;
        $display("FAIL reset_flags: got act/lt/ft=%b expected 000",
                 {o_act, o_lt, o_ft});
      end
      n_tests++;
      if ({o_hs, o_vs, o_ao} !== 3'b110) begin
        n_fail++;
        $display("FAIL reset_conn: got hs/vs/ao=%b expected 110",
                 {o_hs, o_vs, o_ao});
      end
    end
  endtask

  task automatic test_first_line();
    int lt_cnt = 0;
    int hs_low = 0;
    use_cfg(0);
    model_reset();
    rst_a_n = 1'b1;
    #1;
    n_tests++;
    if (o_h !== 12'd0 || o_lt !== 1'b0 || o_ft !== 1'b0) begin
      n_fail++;
      $display("FAIL first_cycle: got h=%0d lt=%b ft=%b expected 0 0 0",
               o_h, o_lt, o_ft);
    end
    for (int i = 1; i <= 1600; i++) begin
      step(1);
      n_tests++;
      if (o_h !== 12'(mh) || o_lt !== m_lt) begin
        n_fail++;
        $display("FAIL line_cnt: got h=%0d lt=%b expected %0d %b",
                 o_h, o_lt, mh, m_lt);
      end
      n_tests++;
      if (o_hs !== e_hso) begin
        n_fail++;
        $display("FAIL hsync_dly: got %b expected %b at h=%0d",
                 o_hs, e_hso, o_h);
      end
      if (o_h == 12'd97 && i > 800) begin
        n_tests++;
        if (o_hs !== 1'b0) begin
          n_fail++;
          $display("FAIL hsync_edge97: got %b expected 0", o_hs);
        end
      end
      if (o_h == 12'd98 && i > 800) begin
        n_tests++;
        if (o_hs !== 1'b1) begin
          n_fail++;
          $display("FAIL hsync_edge98: got %b expected 1", o_hs);
        end
      end
      if (i <= 800 && o_lt) lt_cnt++;
      if (i > 800 && !o_hs) hs_low++;
    end
    n_tests++;
    if (lt_cnt != 1) begin
      n_fail++;
      $display("FAIL line_tick_count: got %0d expected 1", lt_cnt);
    end
    n_tests++;
    if (hs_low != 96) begin
      n_fail++;
      $display("FAIL hsync_width: got %0d expected 96", hs_low);
    end
  endtask

  task automatic test_active_boundary();
    bit rise_seen = 0;
    bit fall_seen = 0;
    bit prev = 0;
    int n = 0;
    use_cfg(0);
    while (!(o_v == 12'd36 && o_h == 12'd0) && n < 30000) begin
      prev = o_act;
      step(1);
      n++;
      n_tests++;
      if (o_act !== m_act || o_v !== 12'(mv) || o_ao !== e_aso) begin
        n_fail++;
        $display("FAIL active_track: got act=%b v=%0d ao=%b expected %b %0d %b",
                 o_act, o_v, o_ao, m_act, mv, e_aso);
      end
      if (!prev && o_act && !rise_seen) begin
        rise_seen = 1;
        n_tests++;
        if (o_h !== 12'd144 || o_v !== 12'd35) begin
          n_fail++;
          $display("FAIL active_rise: got h=%0d v=%0d expected 144 35",
                   o_h, o_v);
        end
      end
      if (prev && !o_act && !fall_seen) begin
        fall_seen = 1;
        n_tests++;
        if (o_h !== 12'd784) begin
          n_fail++;
          $display("FAIL active_fall: got h=%0d expected 784", o_h);
        end
      end
    end
    n_tests++;
    if (!(rise_seen && fall_seen) || n >= 30000) begin
      n_fail++;
      $display("FAIL active_edges_seen: got rise=%b fall=%b expected 1 1",
               rise_seen, fall_seen);
    end
    rst_a_n = 1'b0;
  endtask

  task automatic test_full_frame();
    int n = 0;
    int ft_cnt = 0;
    int vs_low = 0;
    int act_hi = 0;
    use_cfg(1);
    model_reset();
    rst_b_n = 1'b1;
    while (!o_ft && n < 1216) begin
      step(1);
      n++;
    end
    n_tests++;
    if (!o_ft || n != 608) begin
      n_fail++;
      $display("FAIL first_frame_tick: got n=%0d expected 608", n);
    end
    for (int i = 1; i <= 608; i++) begin
      step(1);
      n_tests++;
      if (o_h !== 12'(mh) || o_v !== 12'(mv) || o_ft !== m_ft) begin
        n_fail++;
        $display("FAIL frame_cnt: got h=%0d v=%0d ft=%b expected %0d %0d %b",
                 o_h, o_v, o_ft, mh, mv, m_ft);
      end
      if (o_v == 12'd17) begin
        n_tests++;
        if (o_act !== 1'b0) begin
          n_fail++;
          $display("FAIL active_v17: got %b expected 0", o_act);
        end
      end
      if (o_ft) ft_cnt++;
      if (!o_vs) vs_low++;
      if (o_act) act_hi++;
    end
    n_tests++;
    if (ft_cnt != 1 || !o_ft) begin
      n_fail++;
      $display("FAIL frame_period: got ticks=%0d last=%b expected 1 1",
               ft_cnt, o_ft);
    end
    n_tests++;
    if (vs_low != 64) begin
      n_fail++;
      $display("FAIL vsync_width: got %0d expected 64", vs_low);
    end
    n_tests++;
    if (act_hi != 240) begin
      n_fail++;
      $display("FAIL active_count: got %0d expected 240", act_hi);
    end
  endtask

  task automatic test_ena_hold();
    int n = 0;
    use_cfg(1);
    while (!(o_h == 12'd15 && o_v == 12'd8) && n < 700) begin
      step(1);
      n++;
    end
    n_tests++;
    if (n >= 700) begin
      n_fail++;
      $display("FAIL hold_reach: got h=%0d v=%0d expected 15 8", o_h, o_v);
    end
    for (int i = 0; i < 10; i++) begin
      step(0);
      n_tests++;
      if (o_h !== 12'd15 || o_v !== 12'd8 || o_lt || o_ft) begin
        n_fail++;
        $display("FAIL hold: got h=%0d v=%0d lt=%b ft=%b expected 15 8 0 0",
                 o_h, o_v, o_lt, o_ft);
      end
      n_tests++;
      if ({o_hs, o_vs, o_ao} !== {e_hso, e_vso, e_aso}) begin
        n_fail++;
        $display("FAIL hold_drain: got %b expected %b",
                 {o_hs, o_vs, o_ao}, {e_hso, e_vso, e_aso});
      end
    end
    step(1);
    n_tests++;
    if (o_h !== 12'd16 || o_v !== 12'd8) begin
      n_fail++;
      $display("FAIL resume: got h=%0d v=%0d expected 16 8", o_h, o_v);
    end
  endtask

  task automatic test_random_ena();
    logic [29:0] got, exp;
    use_cfg(1);
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0);
      got = {o_h, o_v, o_act, o_lt, o_ft, o_hs, o_vs, o_ao};
      exp = {12'(mh), 12'(mv), m_act, m_lt, m_ft, e_hso, e_vso, e_aso};
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL random: got %h expected %h (h,v,act,lt,ft,hs,vs,ao)",
                 got, exp);
      end
`ifdef VGA_TIMING_PIXEL_XY_EN
      n_tests++;
      if ({b_px, b_py} !== {10'(m_act ? mh - cf_ha0 : 0),
                            10'(m_act ? mv - cf_va0 : 0)}) begin
        n_fail++;
        $display("FAIL pix_xy: got %0d,%0d at h=%0d v=%0d",
                 b_px, b_py, mh, mv);
      end
`endif
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    use_cfg(1);
    while (!(o_h == 12'd10 && o_v == 12'd7) && n < 700) begin
      step(1);
      n++;
    end
    rst_b_n = 1'b0;
    #1;
    n_tests++;
    if ({o_h, o_v, o_act, o_lt, o_ft, o_hs, o_vs, o_ao}
        !== {24'd0, 6'b000110} || n >= 700) begin
      n_fail++;
      $display("FAIL async_reset: got h=%0d v=%0d flags=%b expected 0 0 000110",
               o_h, o_v, {o_act, o_lt, o_ft, o_hs, o_vs, o_ao});
    end
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({o_h, o_v} !== 24'd0) begin
      n_fail++;
      $display("FAIL reset_hold: got h=%0d v=%0d expected 0 0", o_h, o_v);
    end
    model_reset();
    rst_b_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step(1);
      n_tests++;
      if (o_h !== 12'(mh) || o_v !== 12'(mv)) begin
        n_fail++;
        $display("FAIL restart: got h=%0d v=%0d expected %0d %0d",
                 o_h, o_v, mh, mv);
      end
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_first_line();
    test_active_boundary();
    test_full_frame();
    test_ena_hold();
    test_random_ena();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Free-running 640x480@60 Hz raster timing generator on the 25.175 MHz pixel clock.
- Produces the `h_cnt`, `v_cnt` and `active` signals consumed by the background, sprite and mixer layers.
- Produces `hsync`/`vsync` for the VGA connector, delayed to line up with the registered colour outputs of the layer modules.
- Sits directly upstream of the background layer in the display path.

Parameters:
- H_SYNC_PULSE, 96, horizontal sync width in pixel clocks
- H_BACK_PORCH, 48, horizontal back porch
- H_ACTIVE_TIME, 640, visible pixels per line
- H_FRONT_PORCH, 16, horizontal front porch
- H_LINE_PERIOD, 800, total clocks per line (must equal the sum of the four above)
- V_SYNC_PULSE, 2, vertical sync width in lines
- V_BACK_PORCH, 33, vertical back porch
- V_ACTIVE_TIME, 480, visible lines
- V_FRONT_PORCH, 10, vertical front porch
- V_FRAME_PERIOD, 525, total lines per frame
- SYNC_DELAY, 2, pipeline depth applied to `hsync_out`/`vsync_out`/`active_out`; range 0..7

Ports:
- vga_clk  input  1  pixel clock, 25.175 MHz
- rst_n  input  1  asynchronous reset, active-low
- ena  input  1  count enable; low freezes the raster
- h_cnt  output  12  horizontal position, 0..H_LINE_PERIOD-1
- v_cnt  output  12  vertical position, 0..V_FRAME_PERIOD-1
- active  output  1  visible-area flag, aligned with h_cnt/v_cnt
- frame_tick  output  1  one-cycle pulse at h_cnt=0, v_cnt=0
- line_tick  output  1  one-cycle pulse at h_cnt=0
- hsync_out  output  1  horizontal sync to connector, active-low, delayed SYNC_DELAY
- vsync_out  output  1  vertical sync to connector, active-low, delayed SYNC_DELAY
- active_out  output  1  active delayed SYNC_DELAY, for blanking the final RGB

Behaviour:
- Reset and clocking:
  - One clock: `vga_clk`. Reset `rst_n` is asynchronous and active-low.
  - While `rst_n` is 0, all outputs are forced as follows:
    - `h_cnt` = 0, `v_cnt` = 0
    - `active` = 0, `frame_tick` = 0, `line_tick` = 0
    - `hsync_out` = 1, `vsync_out` = 1, `active_out` = 0
    - every delay-line stage = idle values (sync 1, active 0)
  - Deassertion is used as-is; it is synchronised externally.
- Counters:
  - On each `vga_clk` with `ena`=1, `h_cnt` increments.
  - At H_LINE_PERIOD-1, `h_cnt` wraps to 0 and `v_cnt` increments.
  - At `h_cnt`=H_LINE_PERIOD-1 and `v_cnt`=V_FRAME_PERIOD-1, both wrap to 0 in the same cycle.
- Decode:
  - All decode outputs are registered and computed from the next-state counter values, so they are cycle-aligned with the `h_cnt`/`v_cnt` they describe.
  - Raw hsync = 0 while `h_cnt` < H_SYNC_PULSE.
  - Raw vsync = 0 while `v_cnt` < V_SYNC_PULSE.
  - `active` = 1 while both of these hold:
    - H_SYNC_PULSE+H_BACK_PORCH ≤ `h_cnt` ≤ H_SYNC_PULSE+H_BACK_PORCH+H_ACTIVE_TIME-1, i.e. 144..783
    - V_SYNC_PULSE+V_BACK_PORCH ≤ `v_cnt` ≤ V_SYNC_PULSE+V_BACK_PORCH+V_ACTIVE_TIME-1, i.e. 35..514
- Ticks:
  - `line_tick` = 1 exactly in the cycle where `h_cnt`=0.
  - `frame_tick` = 1 exactly in the cycle where `h_cnt`=0 and `v_cnt`=0.
  - The first cycle after reset release presents count 0, 0 with both ticks low. The first ticks occur at the first wrap.
- Delay line:
  - Raw hsync, raw vsync and `active` pass through a SYNC_DELAY-stage shift register to produce `hsync_out`, `vsync_out` and `active_out`.
  - With SYNC_DELAY=0, the outputs equal the raw registered values.
- `ena`=0:
  - Counters and decode registers hold their values.
  - Ticks are forced to 0.
  - The delay line keeps shifting, so the connector outputs drain to the frozen values after SYNC_DELAY cycles.
- Reset mid-frame: counters return to 0, 0 immediately, with no partial-line completion.
- Widths: 12-bit counters are sufficient for every period up to 4095. Comparison constants are computed at elaboration.

Optional Feature:
- Macro: VGA_TIMING_PIXEL_XY_EN.
- When defined:
  - Adds outputs `pix_x` [9:0] = `h_cnt`-144 and `pix_y` [9:0] = `v_cnt`-35. Both are registered and aligned with `active`.
  - Both read 0 whenever `active`=0 and during reset.
- When undefined: the ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package `vga_pkg` holds the 640x480 timing constants, derived H_ACT_START/H_ACT_END/V_ACT_START/V_ACT_END, and the counter width constant CNT_W=12.
- The layer modules share `vga_pkg`.
- One sub-module: `sync_delay_line`, a parameterised-depth shift register with a reset value per bit, used for the sync/active delay.

Test Plan:
- Reset release with `ena`=1, run 800 clocks:
  - `h_cnt` goes 0..799 then 0.
  - `line_tick` pulses once at the wrap.
  - raw hsync is low for exactly 96 clocks starting at `h_cnt`=0.
- Run a full frame of 420000 clocks:
  - `frame_tick` pulses once, with period exactly 420000.
  - `vsync_out` is low for 1600 clocks.
  - `active` is high for 307200 clocks.
- Boundary check: `active` rises at `h_cnt`=144, `v_cnt`=35 and falls after `h_cnt`=783; it stays 0 for `v_cnt`=515.
- With SYNC_DELAY=2: `hsync_out` equals raw hsync delayed exactly 2 clocks, checked at the 0→1 edge at `h_cnt`=96.
- `ena` low for 10 clocks at `h_cnt`=500, `v_cnt`=100:
  - counters hold 500/100 and ticks stay 0.
  - after re-enable, counting resumes at 501.
- `rst_n` pulsed low at `h_cnt`=300, `v_cnt`=200 for 3 clocks:
  - outputs go to reset values asynchronously, before the next edge.
  - after release, counting restarts from 0, 0.
